// File: rtl/audio_dac.sv
// audio_dac: first-order sigma-delta (pulse-density) audio DAC with an
// underrun watchdog. When no sample arrives for 2**TIMEOUT_BITS enabled
// steps, the output falls back to midscale (silence) and underruns are counted.
// Optional feature: define AUDIO_DAC_DITHER_EN to add a 16-bit LFSR whose
// bit 0 is used as the modulator carry-in (dither). Without it, carry-in is 0.
//
// Input protocol: sample_valid is a one-cycle strobe with no back-pressure
// (there is no ready). The sample is taken on every cycle where sample_valid
// is high, whatever enable is doing and whatever state the block is in.
module audio_dac #(
  parameter int A_BITS       = 11,
  parameter int TIMEOUT_BITS = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic [A_BITS-1:0] sample,
  output logic              audio_out,
  output logic              muted,
  output logic [7:0]        underrun_count,
  output logic              state_dbg
);

  typedef enum logic {
    S_MUTE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [A_BITS-1:0] MIDSCALE = {1'b1, {(A_BITS-1){1'b0}}};

  state_t                  r_state;
  state_t                  w_state_next;
  logic [A_BITS-1:0]       r_held;
  logic [A_BITS-1:0]       r_acc;
  logic                    r_out;
  logic [TIMEOUT_BITS-1:0] r_timeout;
  logic [7:0]              r_underrun;

  logic [A_BITS-1:0]       w_level;
  logic [A_BITS:0]         w_sum;
  logic                    w_cin;
  logic                    w_timeout_max;
  logic                    w_underrun;

  assign w_timeout_max = &r_timeout;
  // The step always uses the level as it stood before this edge: midscale on
  // the MUTE->RUN cycle, the old held value when a new sample lands together
  // with enable, and the held value on the RUN->MUTE cycle.
  assign w_level    = (r_state == S_RUN) ? r_held : MIDSCALE;
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_level} + {{A_BITS{1'b0}}, w_cin};
  assign w_underrun = (r_state == S_RUN) && (w_state_next == S_MUTE);

`ifdef AUDIO_DAC_DITHER_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  // Fibonacci taps 16,14,13,11 (bits 15,13,12,10).
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_cin     = r_lfsr[0];

  // Dither LFSR: advances once per enabled step, after its bit 0 was used.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= 16'hACE1;
    end else if (enable) begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end
`else
  assign w_cin = 1'b0;
`endif

  // Next-state logic: any valid sample starts playback, an expired
  // watchdog on an enabled step without a sample mutes.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_MUTE: if (sample_valid) w_state_next = S_RUN;
      S_RUN:  if (enable && !sample_valid && w_timeout_max) w_state_next = S_MUTE;
      default: w_state_next = S_MUTE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_MUTE;
    else       r_state <= w_state_next;
  end

  // Held sample, converted from two's complement to offset binary on capture.
  // It survives an underrun; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)             r_held <= '0;
    else if (sample_valid) r_held <= {~sample[A_BITS-1], sample[A_BITS-2:0]};
  end

  // Modulator: accumulator keeps the low bits, the carry is the output pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_out <= 1'b0;
    end else if (enable) begin
      r_acc <= w_sum[A_BITS-1:0];
      r_out <= w_sum[A_BITS];
    end
  end

  // Watchdog: counts enabled steps since the last sample while running. The
  // wrap from all-ones coincides with the drop to MUTE, so MUTE sees zero.
  always_ff @(posedge clk) begin
    if (reset)                              r_timeout <= '0;
    else if (sample_valid)                  r_timeout <= '0;
    else if (r_state == S_RUN && enable)    r_timeout <= r_timeout + 1'b1;
  end

  // Saturating underrun counter.
  always_ff @(posedge clk) begin
    if (reset)                                   r_underrun <= '0;
    else if (w_underrun && r_underrun != 8'hFF)  r_underrun <= r_underrun + 8'd1;
  end

  assign audio_out      = r_out;
  assign muted          = (r_state == S_MUTE);
  assign underrun_count = r_underrun;
  assign state_dbg      = r_state;

endmodule

// File: tb/tb_audio_dac.sv
// tb_audio_dac: directed scenarios plus randomized traffic for audio_dac,
// checked every cycle against a behavioural model of the modulator.
module tb_audio_dac;

  localparam int A_BITS = 11;
  localparam int FULL   = 2 ** A_BITS;       // 2048
  localparam int MID    = 2 ** (A_BITS - 1); // 1024
  localparam int TMO    = 2 ** 10;           // enabled idle steps to underrun
  localparam int SAT_TMO = 2 ** 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              sample_valid = 1'b0;
  logic [A_BITS-1:0] sample = '0;
  logic              audio_out;
  logic              muted;
  logic [7:0]        underrun_count;
  logic              state_dbg;

  logic              sat_reset = 1'b1;
  logic              sat_enable = 1'b0;
  logic              sat_valid = 1'b0;
  logic              sat_out;
  logic              sat_muted;
  logic [7:0]        sat_ur;
  logic              sat_state;

  audio_dac #(.A_BITS(A_BITS), .TIMEOUT_BITS(10)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
    .sample(sample), .audio_out(audio_out), .muted(muted),
    .underrun_count(underrun_count), .state_dbg(state_dbg)
  );

  // Short watchdog instance so saturation of the underrun counter is reachable.
  audio_dac #(.A_BITS(A_BITS), .TIMEOUT_BITS(3)) u_sat (
    .clk(clk), .reset(sat_reset), .enable(sat_enable), .sample_valid(sat_valid),
    .sample({A_BITS{1'b0}}), .audio_out(sat_out), .muted(sat_muted),
    .underrun_count(sat_ur), .state_dbg(sat_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Playback flag, held level (offset binary as an integer), enabled idle
  // steps since last sample, accumulator value and last pulse.
  bit m_run;
  int m_held, m_idle, m_acc, m_out, m_under;
  int ones_cnt;

  task automatic model_reset();
    m_run = 0; m_held = 0; m_idle = 0; m_acc = 0; m_out = 0; m_under = 0;
  endtask

  task automatic model_step(input bit v, input bit e, input int s);
    int level, total;
    level = m_run ? m_held : MID;
    if (e) begin
      total = m_acc + level;
      m_out = (total >= FULL) ? 1 : 0;
      m_acc = total % FULL;
    end
    if (v) begin
      m_run  = 1;
      m_idle = 0;
      m_held = s + MID;
    end else if (m_run && e) begin
      if (m_idle == TMO - 1) begin
        m_run  = 0;
        m_idle = 0;
        if (m_under < 255) m_under++;
      end else begin
        m_idle++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit v, input bit e, input int s);
    logic [31:0] sv;
    sv = s;
    sample_valid = v;
    enable       = e;
    sample       = sv[A_BITS-1:0];
    @(posedge clk);
    #1;
    model_step(v, e, s);
    check("audio_out", audio_out, m_out);
    check("muted", muted, !m_run);
    check("underrun_count", underrun_count, m_under);
    if (e && audio_out) ones_cnt++;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    sample_valid = 1'b1;
    enable       = 1'b1;
    sample       = A_BITS'($urandom_range(0, FULL - 1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("rst_audio_out", audio_out, 0);
    check("rst_muted", muted, 1);
    check("rst_underrun", underrun_count, 0);
  endtask

  function automatic int rand_sample();
    return int'($urandom_range(0, FULL - 1)) - MID;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int s, modv;
    bit v, e;

    do_reset();

    // Muted at midscale: alternating pulses from the first step.
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 0);
      check("mute_alternate", audio_out, k % 2);
    end

    // Full-scale positive sample, refreshed every step so it never times out.
    step(1, 0, 1023);
    ones_cnt = 0;
    for (int k = 0; k < FULL; k++) step(1, 1, 1023);
    check("ones_plus1023", ones_cnt, 2047);

    // Most negative sample gives no pulses at all.
    step(1, 0, -1024);
    ones_cnt = 0;
    for (int k = 0; k < FULL; k++) step(1, 1, -1024);
    check("ones_minus1024", ones_cnt, 0);

    // New sample together with enable: that step still uses the old level
    // (held 0 => no carry possible), then 3/4 density.
    step(1, 1, 512);
    check("same_cycle_old_level", audio_out, 0);
    ones_cnt = 0;
    for (int k = 0; k < FULL; k++) step(1, 1, 512);
    check("ones_plus512", ones_cnt, 1536);

    // Underrun: one sample then exactly the watchdog window of idle steps.
    do_reset();
    step(1, 1, rand_sample());
    for (int k = 0; k < TMO - 1; k++) step(0, 1, 0);
    check("pre_timeout_muted", muted, 0);
    step(0, 1, 0);
    check("timeout_muted", muted, 1);
    check("timeout_underrun", underrun_count, 1);
    ones_cnt = 0;
    for (int k = 0; k < FULL; k++) step(0, 1, 0);
    check("ones_after_underrun", ones_cnt, MID);

    // Reset in the middle of playback.
    step(1, 1, 700);
    for (int k = 0; k < 5; k++) step(0, 1, 0);
    do_reset();
    for (int k = 0; k < 4; k++) step(0, 1, 0);

    // Randomized traffic: alternating sparse/dense samples and enable duty.
    for (int seg = 0; seg < 8; seg++) begin
      modv = (seg % 2) ? 4 : 1500;
      for (int n = 0; n < 2500; n++) begin
        v = ($urandom_range(0, modv - 1) == 0);
        e = (seg >= 4) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
        step(v, e, rand_sample());
      end
    end

    step(0, 0, 0);

    // Saturation of the underrun counter on the short-watchdog instance.
    @(posedge clk);
    #1;
    sat_reset = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      sat_valid  = 1'b1;
      sat_enable = 1'b0;
      @(posedge clk);
      #1;
      sat_valid  = 1'b0;
      sat_enable = 1'b1;
      for (int j = 0; j < SAT_TMO; j++) begin
        @(posedge clk);
        #1;
      end
      check("sat_underrun", sat_ur, (k < 255) ? k : 255);
      check("sat_muted", sat_muted, 1);
    end
    check("sat_final", sat_ur, 255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
